// File: rtl/count_extender_pkg.sv
// Shared types and constants for the count extender and its step classifier.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    STEP_LEGAL   = 2'd0,
    STEP_WRAP_UP = 2'd1,
    STEP_WRAP_DN = 2'd2,
    STEP_SKIP    = 2'd3
  } step_t;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] CNT_MAX = 4'hF;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/count_extender_if.sv
// Bus between the upstream counter monitor and count_extender.
// Carries match_val/match only when COUNT_EXT_MATCH_EN is defined.
interface count_extender_if
  import count_pkg::*;
#(
  parameter int HI_W = 4
);
  logic                  en;
  logic [CNT_W-1:0]      count;
  logic                  up_down;
  logic                  load;
  logic                  clr;
  logic [HI_W+CNT_W-1:0] ext_count;
  logic                  wrap_up;
  logic                  wrap_dn;
  logic                  ovf;
  logic                  skip_err;
  logic                  busy;
`ifdef COUNT_EXT_MATCH_EN
  logic [HI_W+CNT_W-1:0] match_val;
  logic                  match;

  modport master (
    output en, count, up_down, load, clr, match_val,
    input  ext_count, wrap_up, wrap_dn, ovf, skip_err, busy, match
  );

  modport slave (
    input  en, count, up_down, load, clr, match_val,
    output ext_count, wrap_up, wrap_dn, ovf, skip_err, busy, match
  );
`else
  modport master (
    output en, count, up_down, load, clr,
    input  ext_count, wrap_up, wrap_dn, ovf, skip_err, busy
  );

  modport slave (
    input  en, count, up_down, load, clr,
    output ext_count, wrap_up, wrap_dn, ovf, skip_err, busy
  );
`endif
endinterface

// File: rtl/count_extender_step_chk.sv
// Combinational classifier of one counter step (prev -> count) given the direction.
module count_step_chk
  import count_pkg::*;
(
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] count,
  input  logic             up_down,
  output step_t            step
);
  logic [CNT_W-1:0] prev_inc;
  logic [CNT_W-1:0] prev_dec;

  assign prev_inc = prev + CNT_W'(1);
  assign prev_dec = prev - CNT_W'(1);

  // Wraps are tested first so the modulo-16 +/-1 compare never sees them.
  always_comb begin
    step = STEP_SKIP;
    if (up_down == DIR_UP && prev == CNT_MAX && count == '0) begin
      step = STEP_WRAP_UP;
    end else if (up_down == DIR_DN && prev == '0 && count == CNT_MAX) begin
      step = STEP_WRAP_DN;
    end else if (count == prev ||
                 (up_down == DIR_UP && count == prev_inc) ||
                 (up_down == DIR_DN && count == prev_dec)) begin
      step = STEP_LEGAL;
    end
  end

endmodule

// File: rtl/count_extender.sv
// Extends a 4-bit up/down counter to HI_W+4 bits by counting its wraps; flags skips and hi overflow.
// Optional registered compare output is built when COUNT_EXT_MATCH_EN is defined.
module count_extender
  import count_pkg::*;
#(
  parameter int HI_W = 4
) (
  input logic             clk,
  input logic             rst,
  count_extender_if.slave bus
);
  localparam int EXT_W = HI_W + CNT_W;

  state_t           state;
  step_t            step;
  logic [HI_W-1:0]  hi;
  logic [HI_W-1:0]  hi_nxt;
  logic [HI_W:0]    hi_inc;
  logic [HI_W:0]    hi_dec;
  logic [CNT_W-1:0] prev;
  logic [EXT_W-1:0] ext_q;
  logic             wrap_up_q;
  logic             wrap_dn_q;
  logic             ovf_q;
  logic             skip_q;
  logic             busy_q;

  // MSB of the result is the carry/borrow out of the high part.
  function automatic logic [HI_W:0] hi_add_one(input logic [HI_W-1:0] h);
    return {1'b0, h} + {{HI_W{1'b0}}, 1'b1};
  endfunction

  function automatic logic [HI_W:0] hi_sub_one(input logic [HI_W-1:0] h);
    return {1'b0, h} - {{HI_W{1'b0}}, 1'b1};
  endfunction

  count_step_chk u_step_chk (
    .prev    (prev),
    .count   (bus.count),
    .up_down (bus.up_down),
    .step    (step)
  );

  assign hi_inc = hi_add_one(hi);
  assign hi_dec = hi_sub_one(hi);

  // High part after this sample; clr beats load, load beats any wrap.
  always_comb begin
    hi_nxt = hi;
    case (state)
      TRACK: begin
        if (bus.clr) begin
          hi_nxt = '0;
        end else if (!bus.load) begin
          if (step == STEP_WRAP_UP) begin
            hi_nxt = hi_inc[HI_W-1:0];
          end else if (step == STEP_WRAP_DN) begin
            hi_nxt = hi_dec[HI_W-1:0];
          end
        end
      end
      FAULT: begin
        if (bus.clr) begin
          hi_nxt = '0;
        end
      end
      default: hi_nxt = hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      hi        <= '0;
      prev      <= '0;
      ext_q     <= '0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      ovf_q     <= 1'b0;
      skip_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      if (bus.en) begin
        hi    <= hi_nxt;
        prev  <= bus.count;
        ext_q <= {hi_nxt, bus.count};
        case (state)
          IDLE: begin
            if (bus.clr) begin
              ovf_q  <= 1'b0;
              skip_q <= 1'b0;
            end
            state  <= TRACK;
            busy_q <= 1'b1;
          end
          TRACK: begin
            if (bus.clr) begin
              ovf_q  <= 1'b0;
              skip_q <= 1'b0;
            end else if (!bus.load) begin
              case (step)
                STEP_WRAP_UP: begin
                  wrap_up_q <= 1'b1;
                  if (hi_inc[HI_W]) ovf_q <= 1'b1;
                end
                STEP_WRAP_DN: begin
                  wrap_dn_q <= 1'b1;
                  if (hi_dec[HI_W]) ovf_q <= 1'b1;
                end
                STEP_SKIP: begin
                  skip_q <= 1'b1;
                  state  <= FAULT;
                  busy_q <= 1'b0;
                end
                default: ;
              endcase
            end
          end
          FAULT: begin
            if (bus.clr) begin
              ovf_q  <= 1'b0;
              skip_q <= 1'b0;
              state  <= TRACK;
              busy_q <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ext_count = ext_q;
  assign bus.wrap_up   = wrap_up_q;
  assign bus.wrap_dn   = wrap_dn_q;
  assign bus.ovf       = ovf_q;
  assign bus.skip_err  = skip_q;
  assign bus.busy      = busy_q;

`ifdef COUNT_EXT_MATCH_EN
  logic match_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= bus.en && (state == TRACK) && ({hi_nxt, bus.count} == bus.match_val);
    end
  end

  assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_count_extender.sv
// Scoreboard bench for count_extender: directed steps push expected outputs, a monitor pops and compares.
module tb_count_extender;
  import count_pkg::*;

  typedef struct packed {
    logic [7:0] ext;
    logic       wu;
    logic       wd;
    logic       ovf;
    logic       skip;
    logic       busy;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  count_extender_if #(.HI_W(4)) bus ();

  count_extender #(.HI_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [3:0] ref_prev;
  logic [3:0] ref_count;
  logic       ref_ud;
  step_t      ref_step;

  count_step_chk u_ref (
    .prev    (ref_prev),
    .count   (ref_count),
    .up_down (ref_ud),
    .step    (ref_step)
  );

  always #5 clk = ~clk;

  // Monitor: one registered result per clock, checked just after the edge.
  always @(posedge clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus.ext_count, bus.wrap_up, bus.wrap_dn, bus.ovf, bus.skip_err, bus.busy};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ext=%h wu=%b wd=%b ovf=%b skip=%b busy=%b, required ext=%h wu=%b wd=%b ovf=%b skip=%b busy=%b",
                 nm, a.ext, a.wu, a.wd, a.ovf, a.skip, a.busy,
                 e.ext, e.wu, e.wd, e.ovf, e.skip, e.busy);
      end
    end
  end

  task automatic drv(input logic r, input logic e, input logic [3:0] c, input logic ud,
                     input logic ld, input logic cl, input logic [7:0] x, input logic wu,
                     input logic wd, input logic ov, input logic sk, input logic bz,
                     input string nm);
    exp_t ex;
    @(negedge clk);
    rst         = r;
    bus.en      = e;
    bus.count   = c;
    bus.up_down = ud;
    bus.load    = ld;
    bus.clr     = cl;
    ex = '{ext: x, wu: wu, wd: wd, ovf: ov, skip: sk, busy: bz};
    exp_q.push_back(ex);
    name_q.push_back(nm);
  endtask

  task automatic chk_step(input logic [3:0] p, input logic [3:0] c, input logic ud,
                          input step_t req, input string nm);
    ref_prev  = p;
    ref_count = c;
    ref_ud    = ud;
    #1;
    checks++;
    if (ref_step !== req) begin
      errors++;
      $display("FAIL %s: got step=%0d required=%0d", nm, ref_step, req);
    end
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.count   = 4'd0;
    bus.up_down = 1'b1;
    bus.load    = 1'b0;
    bus.clr     = 1'b0;
`ifdef COUNT_EXT_MATCH_EN
    bus.match_val = '1;
`endif

    chk_step(4'd15, 4'd0,  1'b1, STEP_WRAP_UP, "cls_wrap_up");
    chk_step(4'd0,  4'd15, 1'b0, STEP_WRAP_DN, "cls_wrap_dn");
    chk_step(4'd15, 4'd0,  1'b0, STEP_SKIP,    "cls_15_0_down");
    chk_step(4'd0,  4'd15, 1'b1, STEP_SKIP,    "cls_0_15_up");
    chk_step(4'd3,  4'd4,  1'b1, STEP_LEGAL,   "cls_inc");
    chk_step(4'd3,  4'd2,  1'b1, STEP_SKIP,    "cls_dec_while_up");
    chk_step(4'd3,  4'd2,  1'b0, STEP_LEGAL,   "cls_dec");
    chk_step(4'd7,  4'd7,  1'b0, STEP_LEGAL,   "cls_hold");

    //  rst en cnt  ud ld cl  ext  wu wd ov sk bz
    drv(0, 0, 4'd0,  1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "reset0");
    drv(0, 1, 4'd7,  1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "reset_en");
    drv(1, 1, 4'd5,  1, 0, 0, 8'h05, 0, 0, 0, 0, 1, "first_sample");
    drv(1, 1, 4'd14, 1, 1, 0, 8'h0E, 0, 0, 0, 0, 1, "load14");
    drv(1, 1, 4'd15, 1, 0, 0, 8'h0F, 0, 0, 0, 0, 1, "up15");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h10, 1, 0, 0, 0, 1, "wrap_up");
    drv(1, 1, 4'd1,  1, 0, 0, 8'h11, 0, 0, 0, 0, 1, "after_wrap");
    drv(1, 0, 4'd9,  1, 0, 0, 8'h11, 0, 0, 0, 0, 1, "en_hold");
    drv(1, 0, 4'd3,  1, 0, 1, 8'h11, 0, 0, 0, 0, 1, "en_hold_clr");
    drv(1, 1, 4'd1,  0, 0, 1, 8'h01, 0, 0, 0, 0, 1, "clr_hi");
    drv(1, 1, 4'd0,  0, 0, 0, 8'h00, 0, 0, 0, 0, 1, "down0");
    drv(1, 1, 4'd15, 0, 0, 0, 8'hFF, 0, 1, 1, 0, 1, "wrap_dn_ovf");
    drv(1, 1, 4'd14, 0, 0, 0, 8'hFE, 0, 0, 1, 0, 1, "ovf_sticky");
    drv(1, 1, 4'd15, 1, 1, 0, 8'hFF, 0, 0, 1, 0, 1, "load15_hiF");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h00, 1, 0, 1, 0, 1, "wrap_up_ovf");
    drv(1, 1, 4'd3,  1, 0, 1, 8'h03, 0, 0, 0, 0, 1, "clr_flags");
    drv(1, 1, 4'd12, 1, 1, 0, 8'h0C, 0, 0, 0, 0, 1, "load_resync");
    drv(1, 1, 4'd15, 1, 1, 0, 8'h0F, 0, 0, 0, 0, 1, "load15");
    drv(1, 1, 4'd0,  1, 1, 0, 8'h00, 0, 0, 0, 0, 1, "load_on_wrap");
    drv(1, 1, 4'd15, 1, 1, 0, 8'h0F, 0, 0, 0, 0, 1, "load15_b");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h10, 1, 0, 0, 0, 1, "wrap_up_b");
    drv(1, 1, 4'd15, 1, 1, 0, 8'h1F, 0, 0, 0, 0, 1, "load15_hi1");
    drv(1, 1, 4'd0,  1, 0, 1, 8'h00, 0, 0, 0, 0, 1, "clr_on_wrap");
    drv(1, 1, 4'd4,  1, 1, 0, 8'h04, 0, 0, 0, 0, 1, "load4");
    drv(1, 1, 4'd9,  1, 0, 0, 8'h09, 0, 0, 0, 1, 0, "skip_up");
    drv(1, 1, 4'd15, 1, 0, 0, 8'h0F, 0, 0, 0, 1, 0, "fault_track");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h00, 0, 0, 0, 1, 0, "fault_no_wrap");
    drv(1, 0, 4'd5,  1, 0, 1, 8'h00, 0, 0, 0, 1, 0, "fault_clr_no_en");
    drv(1, 1, 4'd5,  1, 0, 1, 8'h05, 0, 0, 0, 0, 1, "fault_recover");
    drv(1, 1, 4'd4,  0, 0, 0, 8'h04, 0, 0, 0, 0, 1, "down_step");
    drv(1, 1, 4'd4,  0, 0, 0, 8'h04, 0, 0, 0, 0, 1, "same_step");
    drv(1, 1, 4'd5,  0, 0, 0, 8'h05, 0, 0, 0, 1, 0, "skip_down");
    drv(1, 1, 4'd5,  1, 0, 1, 8'h05, 0, 0, 0, 0, 1, "recover2");
    drv(1, 1, 4'd15, 1, 1, 0, 8'h0F, 0, 0, 0, 0, 1, "hi3_load_a");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h10, 1, 0, 0, 0, 1, "hi3_wrap_a");
    drv(1, 1, 4'd15, 1, 1, 0, 8'h1F, 0, 0, 0, 0, 1, "hi3_load_b");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h20, 1, 0, 0, 0, 1, "hi3_wrap_b");
    drv(1, 1, 4'd15, 1, 1, 0, 8'h2F, 0, 0, 0, 0, 1, "hi3_load_c");
    drv(1, 1, 4'd0,  1, 0, 0, 8'h30, 1, 0, 0, 0, 1, "hi3_wrap_c");
    drv(1, 1, 4'd1,  1, 0, 0, 8'h31, 0, 0, 0, 0, 1, "hi3_step");
    drv(0, 1, 4'd2,  1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "mid_reset");
    drv(1, 0, 4'd2,  1, 0, 0, 8'h00, 0, 0, 0, 0, 0, "idle_hold");
    drv(1, 1, 4'd8,  0, 0, 0, 8'h08, 0, 0, 0, 0, 1, "idle_first_nochk");
    drv(1, 1, 4'd3,  0, 0, 0, 8'h03, 0, 0, 0, 1, 0, "skip_again");
    drv(0, 1, 4'd3,  0, 0, 0, 8'h00, 0, 0, 0, 0, 0, "reset_fault");
    drv(1, 1, 4'd6,  1, 0, 1, 8'h06, 0, 0, 0, 0, 1, "idle_clr_first");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_extender.md
Name: count_extender

Overview:
- Sits directly downstream of the team's 4-bit synchronous up/down counter (ports `clk`, `rst`, `load`, `up_down`, `data`, `count`).
- Samples the counter's `count` every enabled cycle, detects wrap-around (15->0 counting up, 0->15 counting down) and maintains an extended high part, so the 4-bit counter behaves as a (HI_W+4)-bit counter.
- Also flags illegal jumps (skip faults) and high-part overflow for the monitoring logic.

Parameters:
- HI_W, 4, width of the extended high part; `ext_count` is HI_W+4 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising `clk`)
- en  input  1  sample enable; when 0 the block holds all state and pulse outputs are 0
- count  input  4  current value of the upstream counter
- up_down  input  1  upstream direction: 1 = up, 0 = down
- load  input  1  upstream parallel load occurred this cycle (count discontinuity is legal)
- clr  input  1  clears `hi`, the sticky flags and the FAULT state
- ext_count  output  HI_W+4  {hi, last sampled count}
- wrap_up  output  1  one-cycle pulse on an up wrap
- wrap_dn  output  1  one-cycle pulse on a down wrap
- ovf  output  1  sticky: `hi` wrapped (increment past max or decrement below 0)
- skip_err  output  1  sticky: illegal count step seen
- busy  output  1  1 when the FSM is in TRACK

Behaviour:
- **Reset** (`rst`=0 at the clock edge): state=IDLE, `hi`=0, `prev`=0, `ext_count`=0, `wrap_up`=0, `wrap_dn`=0, `ovf`=0, `skip_err`=0, `busy`=0. Reset overrides everything, including mid-tracking and FAULT.
- **Registering:** all outputs are registered. Effects of a sample taken at edge N are visible after edge N; latency is 1 cycle from `count` to `ext_count`.
- **FSM states:**
  - IDLE: no valid previous sample. On `en`=1: `prev`<=`count`, go to TRACK; no wrap or skip checks on this first sample.
  - TRACK: on `en`=1, evaluate the rules below in priority order.
    1. `clr`=1: `hi`<=0, `ovf`<=0, `skip_err`<=0, `prev`<=`count`; stay in TRACK.
    2. `load`=1: resync only, `prev`<=`count`; no wrap, no skip check.
    3. `up_down`=1, `prev`=15, `count`=0: `wrap_up` pulse, `hi`<=`hi`+1. If `hi` was all-ones it becomes 0 and `ovf`<=1.
    4. `up_down`=0, `prev`=0, `count`=15: `wrap_dn` pulse, `hi`<=`hi`-1. If `hi` was 0 it becomes all-ones and `ovf`<=1.
    5. `count`==`prev`, or `count`==`prev`+1 with `up_down`=1, or `count`==`prev`-1 with `up_down`=0 (4-bit arithmetic, wrap cases excluded): legal step, `prev`<=`count`.
    6. Anything else: `skip_err`<=1, `prev`<=`count`, go to FAULT.
  - FAULT: `busy`=0. `ext_count` tracks {`hi`, `count`} on `en`, with no wrap or skip evaluation. `clr`=1 with `en`=1 clears `hi` and the flags and returns to TRACK with `prev`<=`count`.
- **clr and en:** `clr` is ignored when `en`=0. In IDLE, `clr` only clears the flags.
- **Pulses:** `wrap_up` and `wrap_dn` are never both 1. Each is high for exactly one cycle per wrap.
- **Simultaneous events:** `clr` with a wrap means the clear wins and no pulse is issued. `load` with a wrap pattern means resync wins and no pulse is issued.

Optional Feature:
- Macro `COUNT_EXT_MATCH_EN`.
- Defined: adds input `match_val` [HI_W+3:0] and output `match` (1 bit). `match` is a one-cycle pulse, registered, asserted the cycle after a sample where the next `ext_count` equals `match_val`, in TRACK only.
- Undefined: neither port exists, and there is no compare logic.

Decomposition:
- Shared package `count_pkg`:
  - state typedef: IDLE=2'd0, TRACK=2'd1, FAULT=2'd2
  - localparams CNT_W=4, CNT_MAX=4'hF
  - direction constants DIR_UP=1'b1, DIR_DN=1'b0
- One sub-module, `count_step_chk`: combinational classifier of (`prev`, `count`, `up_down`) into legal / wrap_up / wrap_dn / skip. It is instantiated once and reused by the bench as a reference model.

Test Plan:
- **Reset then first sample:** `rst`=0 for 2 cycles -> all outputs 0. Release; `en`=1, `count`=5 -> `ext_count`=0x05, `busy`=1, no pulses.
- **Up wrap:** `up_down`=1, `count` 14,15,0,1 -> `wrap_up` pulses once after the 0 sample; `ext_count`=0x10 then 0x11.
- **Down wrap and hi underflow:** from `hi`=0, `up_down`=0, `count` 1,0,15 -> `wrap_dn` pulse, `hi`=0xF, `ext_count`=0xFF, `ovf`=1 (sticky).
- **Load resync:** `count` 3, then `load`=1 with `count`=12 -> no `skip_err`; `ext_count`=0x0C.
- **Skip fault and recovery:** `up_down`=1, `count` 4 then 9 with `load`=0 -> `skip_err`=1, `busy`=0. `count` 15 then 0 -> no `wrap_up`. `clr`=1 with `en`=1 -> flags 0, `busy`=1.
- **Mid-operation reset and `en` hold:** `en`=0 while `count` changes -> `ext_count` frozen. `rst`=0 during TRACK with `hi`=3 -> next cycle `ext_count`=0, state IDLE.
